// File: rtl/calc2_dispatch_sched.sv
// calc2 issue scheduler.
// Accepts commands from four request ports and dispatches add/sub to the adder
// and shl/shr to the shifter. Each unit has its own round-robin arbiter. The
// block tracks per-port/per-tag in-flight commands and reports completion
// ({port, tag}) aligned with each unit's fixed latency.
module calc2_dispatch_sched #(
   parameter int unsigned DW        = 32,
   parameter int unsigned ADD_LAT   = 2,
   parameter int unsigned SHIFT_LAT = 3,
   parameter int unsigned MAX_OUT   = 2
) (
   input  logic            c_clk,
   input  logic            reset,
   input  logic [3:0]      req_vld,
   input  logic [15:0]     req_cmd,
   input  logic [7:0]      req_tag,
   input  logic [4*DW-1:0] req_data1,
   input  logic [4*DW-1:0] req_data2,
   output logic [3:0]      req_rdy,
   output logic            prio_adder_issue,
   output logic [3:0]      prio_adder_cmd,
   output logic [DW-1:0]   prio_adder_data1,
   output logic [DW-1:0]   prio_adder_data2,
   output logic            prio_shift_issue,
   output logic [3:0]      prio_shift_cmd,
   output logic [DW-1:0]   prio_shift_data1,
   output logic [DW-1:0]   prio_shift_data2,
   output logic            prio_adder_out_vld,
   output logic [3:0]      prio_adder_tag,
   output logic            prio_shift_out_vld,
   output logic [3:0]      prio_shift_tag,
   output logic [3:0]      port_invalid_op,
   output logic [7:0]      port_invalid_tag
);

   localparam logic [3:0] CmdNop = 4'b0000;
   localparam logic [3:0] CmdAdd = 4'b0001;
   localparam logic [3:0] CmdSub = 4'b0010;
   localparam logic [3:0] CmdShl = 4'b0101;
   localparam logic [3:0] CmdShr = 4'b0110;

   // First requester at or after ptr, wrapping; one-hot (or zero) result.
   function automatic logic [3:0] rr_grant(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] idx;
      rr_grant = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         idx = ptr + 2'(i);
         if (req[idx] && (rr_grant == 4'b0000)) rr_grant[idx] = 1'b1;
      end
   endfunction

   function automatic logic [1:0] onehot_enc(input logic [3:0] oh);
      onehot_enc = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (oh[i]) onehot_enc = 2'(i);
      end
   endfunction

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      popcnt4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Per-port views of the packed request buses (port1 in the low slice).
   logic [3:0][3:0]    cmd;
   logic [3:0][1:0]    tag;
   logic [3:0][DW-1:0] data1;
   logic [3:0][DW-1:0] data2;

   assign cmd   = req_cmd;
   assign tag   = req_tag;
   assign data1 = req_data1;
   assign data2 = req_data2;

   logic [3:0]      is_add, is_shf, is_nop, is_inv;
   logic [3:0]      elig, add_req, shf_req, add_gnt, shf_gnt, inv_acc;
   logic [1:0]      add_sel, shf_sel;
   logic [1:0]      add_ptr_q, shf_ptr_q;
   logic [3:0][3:0] busy_q, busy_d;

   // Adder issue stage.
   logic          add_issue_q;
   logic [3:0]    add_cmd_q;
   logic [DW-1:0] add_d1_q, add_d2_q;
   logic [3:0]    add_id_q;

   // Shifter issue stage.
   logic          shf_issue_q;
   logic [3:0]    shf_cmd_q;
   logic [DW-1:0] shf_d1_q, shf_d2_q;
   logic [3:0]    shf_id_q;

   // Latency pipelines carrying {port, tag} behind each issue stage.
   logic [ADD_LAT-1:0]        add_pipe_vld_q;
   logic [ADD_LAT-1:0][3:0]   add_pipe_id_q;
   logic [SHIFT_LAT-1:0]      shf_pipe_vld_q;
   logic [SHIFT_LAT-1:0][3:0] shf_pipe_id_q;

   logic       add_done, shf_done;
   logic [3:0] add_done_id, shf_done_id;

   logic [3:0]      inv_q;
   logic [3:0][1:0] inv_tag_q;

   // Classify each port's command and decide whether it may issue now.
   always_comb begin
      is_add = 4'b0000;
      is_shf = 4'b0000;
      is_nop = 4'b0000;
      is_inv = 4'b0000;
      elig   = 4'b0000;
      for (int p = 0; p < 4; p++) begin
         case (cmd[p])
            CmdAdd, CmdSub: is_add[p] = 1'b1;
            CmdShl, CmdShr: is_shf[p] = 1'b1;
            CmdNop:         is_nop[p] = 1'b1;
            default:        is_inv[p] = 1'b1;
         endcase
         elig[p] = req_vld[p] && !busy_q[p][tag[p]] &&
                   ({29'd0, popcnt4(busy_q[p])} < MAX_OUT);
      end
   end

   assign add_req = elig & is_add;
   assign shf_req = elig & is_shf;
   assign add_gnt = rr_grant(add_req, add_ptr_q);
   assign shf_gnt = rr_grant(shf_req, shf_ptr_q);
   assign add_sel = onehot_enc(add_gnt);
   assign shf_sel = onehot_enc(shf_gnt);
   assign inv_acc = req_vld & is_inv;

   // NOP and invalid commands never stall; they are consumed on sight.
   assign req_rdy = add_gnt | shf_gnt | (req_vld & (is_nop | is_inv));

   // Adder issue register and its round-robin pointer.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         add_issue_q <= 1'b0;
         add_cmd_q   <= '0;
         add_d1_q    <= '0;
         add_d2_q    <= '0;
         add_id_q    <= '0;
         add_ptr_q   <= 2'd0;
      end else begin
         add_issue_q <= |add_gnt;
         if (|add_gnt) begin
            add_cmd_q <= cmd[add_sel];
            add_d1_q  <= data1[add_sel];
            add_d2_q  <= data2[add_sel];
            add_id_q  <= {add_sel, tag[add_sel]};
            add_ptr_q <= add_sel + 2'd1;
         end
      end
   end

   // Shifter issue register and its round-robin pointer.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         shf_issue_q <= 1'b0;
         shf_cmd_q   <= '0;
         shf_d1_q    <= '0;
         shf_d2_q    <= '0;
         shf_id_q    <= '0;
         shf_ptr_q   <= 2'd0;
      end else begin
         shf_issue_q <= |shf_gnt;
         if (|shf_gnt) begin
            shf_cmd_q <= cmd[shf_sel];
            shf_d1_q  <= data1[shf_sel];
            shf_d2_q  <= data2[shf_sel];
            shf_id_q  <= {shf_sel, tag[shf_sel]};
            shf_ptr_q <= shf_sel + 2'd1;
         end
      end
   end

   // Adder latency pipeline; its tail marks the cycle the adder result is valid.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         add_pipe_vld_q <= '0;
         add_pipe_id_q  <= '0;
      end else begin
         add_pipe_vld_q[0] <= add_issue_q;
         add_pipe_id_q[0]  <= add_id_q;
         for (int i = 1; i < int'(ADD_LAT); i++) begin
            add_pipe_vld_q[i] <= add_pipe_vld_q[i-1];
            add_pipe_id_q[i]  <= add_pipe_id_q[i-1];
         end
      end
   end

   // Shifter latency pipeline; its tail marks the cycle the shifter result is valid.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         shf_pipe_vld_q <= '0;
         shf_pipe_id_q  <= '0;
      end else begin
         shf_pipe_vld_q[0] <= shf_issue_q;
         shf_pipe_id_q[0]  <= shf_id_q;
         for (int i = 1; i < int'(SHIFT_LAT); i++) begin
            shf_pipe_vld_q[i] <= shf_pipe_vld_q[i-1];
            shf_pipe_id_q[i]  <= shf_pipe_id_q[i-1];
         end
      end
   end

   assign add_done    = add_pipe_vld_q[ADD_LAT-1];
   assign add_done_id = add_pipe_id_q[ADD_LAT-1];
   assign shf_done    = shf_pipe_vld_q[SHIFT_LAT-1];
   assign shf_done_id = shf_pipe_id_q[SHIFT_LAT-1];

   // In-flight table: completions clear, grants set. A granted bit is never
   // the one completing, since a busy tag cannot be granted again.
   always_comb begin
      busy_d = busy_q;
      if (add_done) busy_d[add_done_id[3:2]][add_done_id[1:0]] = 1'b0;
      if (shf_done) busy_d[shf_done_id[3:2]][shf_done_id[1:0]] = 1'b0;
      for (int p = 0; p < 4; p++) begin
         if (add_gnt[p] || shf_gnt[p]) busy_d[p][tag[p]] = 1'b1;
      end
   end

   // In-flight table and invalid-command pulse registers.
   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         busy_q    <= '0;
         inv_q     <= 4'b0000;
         inv_tag_q <= '0;
      end else begin
         busy_q <= busy_d;
         inv_q  <= inv_acc;
         for (int p = 0; p < 4; p++) begin
            if (inv_acc[p]) inv_tag_q[p] <= tag[p];
         end
      end
   end

   assign prio_adder_issue   = add_issue_q;
   assign prio_adder_cmd     = add_cmd_q;
   assign prio_adder_data1   = add_d1_q;
   assign prio_adder_data2   = add_d2_q;
   assign prio_shift_issue   = shf_issue_q;
   assign prio_shift_cmd     = shf_cmd_q;
   assign prio_shift_data1   = shf_d1_q;
   assign prio_shift_data2   = shf_d2_q;
   assign prio_adder_out_vld = add_done;
   assign prio_adder_tag     = add_done_id;
   assign prio_shift_out_vld = shf_done;
   assign prio_shift_tag     = shf_done_id;
   assign port_invalid_op    = inv_q;
   assign port_invalid_tag   = inv_tag_q;

endmodule

// File: tb/tb_calc2_dispatch_sched.sv
// Bench for calc2_dispatch_sched: directed scenarios with literal expectations
// plus a schedule-based reference model checked every cycle.
// Vectors are numeric: bit p of req_rdy / port_invalid_op is port p+1.
module tb_calc2_dispatch_sched;

   localparam int unsigned DW        = 32;
   localparam int unsigned ADD_LAT   = 2;
   localparam int unsigned SHIFT_LAT = 3;
   localparam int unsigned MAX_OUT   = 2;
   localparam int          NSLOT     = 64;

   localparam logic [3:0] ADD = 4'b0001;
   localparam logic [3:0] SUB = 4'b0010;
   localparam logic [3:0] SHL = 4'b0101;
   localparam logic [3:0] SHR = 4'b0110;
   localparam logic [3:0] NOP = 4'b0000;

   logic            c_clk = 1'b0;
   logic            reset = 1'b0;
   logic [3:0]      req_vld;
   logic [15:0]     req_cmd;
   logic [7:0]      req_tag;
   logic [4*DW-1:0] req_data1, req_data2;
   logic [3:0]      req_rdy;
   logic            prio_adder_issue, prio_shift_issue;
   logic [3:0]      prio_adder_cmd, prio_shift_cmd;
   logic [DW-1:0]   prio_adder_data1, prio_adder_data2, prio_shift_data1, prio_shift_data2;
   logic            prio_adder_out_vld, prio_shift_out_vld;
   logic [3:0]      prio_adder_tag, prio_shift_tag;
   logic [3:0]      port_invalid_op;
   logic [7:0]      port_invalid_tag;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 c_clk = ~c_clk;

   calc2_dispatch_sched #(
      .DW(DW), .ADD_LAT(ADD_LAT), .SHIFT_LAT(SHIFT_LAT), .MAX_OUT(MAX_OUT)
   ) dut (
      .c_clk(c_clk), .reset(reset),
      .req_vld(req_vld), .req_cmd(req_cmd), .req_tag(req_tag),
      .req_data1(req_data1), .req_data2(req_data2), .req_rdy(req_rdy),
      .prio_adder_issue(prio_adder_issue), .prio_adder_cmd(prio_adder_cmd),
      .prio_adder_data1(prio_adder_data1), .prio_adder_data2(prio_adder_data2),
      .prio_shift_issue(prio_shift_issue), .prio_shift_cmd(prio_shift_cmd),
      .prio_shift_data1(prio_shift_data1), .prio_shift_data2(prio_shift_data2),
      .prio_adder_out_vld(prio_adder_out_vld), .prio_adder_tag(prio_adder_tag),
      .prio_shift_out_vld(prio_shift_out_vld), .prio_shift_tag(prio_shift_tag),
      .port_invalid_op(port_invalid_op), .port_invalid_tag(port_invalid_tag)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   bit            m_busy [4][4];
   int            m_add_ptr, m_shf_ptr;
   bit            e_ai [NSLOT];
   logic [3:0]    e_ac [NSLOT];
   logic [DW-1:0] e_ad1 [NSLOT], e_ad2 [NSLOT];
   bit            e_si [NSLOT];
   logic [3:0]    e_sc [NSLOT];
   logic [DW-1:0] e_sd1 [NSLOT], e_sd2 [NSLOT];
   bit            e_ao [NSLOT], e_so [NSLOT];
   logic [3:0]    e_at [NSLOT], e_st [NSLOT];
   logic [3:0]    e_inv [NSLOT];
   logic [1:0]    e_invt [NSLOT][4];
   int            cyc = 0;

   function automatic bit f_add(input logic [3:0] c);
      return (c == ADD) || (c == SUB);
   endfunction
   function automatic bit f_shf(input logic [3:0] c);
      return (c == SHL) || (c == SHR);
   endfunction

   // Compare against the schedule, then advance the model by one cycle.
   always @(negedge c_clk) begin : compare
      int s, s1, pa, ps, cnt, p;
      logic [3:0] exp_rdy, c;
      logic [1:0] t;
      bit elig [4];
      if (!reset) begin
         for (int i = 0; i < NSLOT; i++) begin
            e_ai[i] = 0; e_si[i] = 0; e_ao[i] = 0; e_so[i] = 0; e_inv[i] = 4'b0000;
         end
         for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) m_busy[i][j] = 0;
         m_add_ptr = 0;
         m_shf_ptr = 0;
         chk("rst_adder_issue", {63'd0, prio_adder_issue}, 0);
         chk("rst_shift_issue", {63'd0, prio_shift_issue}, 0);
         chk("rst_adder_out_vld", {63'd0, prio_adder_out_vld}, 0);
         chk("rst_shift_out_vld", {63'd0, prio_shift_out_vld}, 0);
         chk("rst_invalid_op", {60'd0, port_invalid_op}, 0);
      end else begin
         s  = cyc % NSLOT;
         s1 = (cyc + 1) % NSLOT;
         chk("adder_issue", {63'd0, prio_adder_issue}, {63'd0, e_ai[s]});
         if (e_ai[s]) begin
            chk("adder_cmd", {60'd0, prio_adder_cmd}, {60'd0, e_ac[s]});
            chk("adder_data1", {32'd0, prio_adder_data1}, {32'd0, e_ad1[s]});
            chk("adder_data2", {32'd0, prio_adder_data2}, {32'd0, e_ad2[s]});
         end
         chk("shift_issue", {63'd0, prio_shift_issue}, {63'd0, e_si[s]});
         if (e_si[s]) begin
            chk("shift_cmd", {60'd0, prio_shift_cmd}, {60'd0, e_sc[s]});
            chk("shift_data1", {32'd0, prio_shift_data1}, {32'd0, e_sd1[s]});
            chk("shift_data2", {32'd0, prio_shift_data2}, {32'd0, e_sd2[s]});
         end
         chk("adder_out_vld", {63'd0, prio_adder_out_vld}, {63'd0, e_ao[s]});
         if (e_ao[s]) chk("adder_tag", {60'd0, prio_adder_tag}, {60'd0, e_at[s]});
         chk("shift_out_vld", {63'd0, prio_shift_out_vld}, {63'd0, e_so[s]});
         if (e_so[s]) chk("shift_tag", {60'd0, prio_shift_tag}, {60'd0, e_st[s]});
         chk("invalid_op", {60'd0, port_invalid_op}, {60'd0, e_inv[s]});
         for (int q = 0; q < 4; q++)
            if (e_inv[s][q]) chk("invalid_tag", {62'd0, port_invalid_tag[q*2 +: 2]},
                                 {62'd0, e_invt[s][q]});

         // Which requests this cycle can issue, and who wins each unit.
         exp_rdy = 4'b0000;
         for (int q = 0; q < 4; q++) begin
            c = req_cmd[q*4 +: 4];
            t = req_tag[q*2 +: 2];
            cnt = 0;
            for (int j = 0; j < 4; j++) cnt += m_busy[q][j];
            elig[q] = req_vld[q] && !m_busy[q][t] && (cnt < int'(MAX_OUT));
            if (req_vld[q] && !f_add(c) && !f_shf(c)) exp_rdy[q] = 1'b1;
            if (req_vld[q] && (c != NOP) && !f_add(c) && !f_shf(c)) begin
               e_inv[s1][q]  = 1'b1;
               e_invt[s1][q] = t;
            end
         end
         pa = -1;
         ps = -1;
         for (int i = 0; i < 4; i++) begin
            p = (m_add_ptr + i) % 4;
            if (pa < 0 && elig[p] && f_add(req_cmd[p*4 +: 4])) pa = p;
            p = (m_shf_ptr + i) % 4;
            if (ps < 0 && elig[p] && f_shf(req_cmd[p*4 +: 4])) ps = p;
         end
         if (pa >= 0) exp_rdy[pa] = 1'b1;
         if (ps >= 0) exp_rdy[ps] = 1'b1;
         chk("req_rdy", {60'd0, req_rdy}, {60'd0, exp_rdy});

         // Completions this cycle free their tags at the coming edge.
         if (e_ao[s]) m_busy[e_at[s][3:2]][e_at[s][1:0]] = 0;
         if (e_so[s]) m_busy[e_st[s][3:2]][e_st[s][1:0]] = 0;

         if (pa >= 0) begin
            t = req_tag[pa*2 +: 2];
            e_ai[s1] = 1; e_ac[s1] = req_cmd[pa*4 +: 4];
            e_ad1[s1] = req_data1[pa*DW +: DW]; e_ad2[s1] = req_data2[pa*DW +: DW];
            e_ao[(cyc + 1 + ADD_LAT) % NSLOT] = 1;
            e_at[(cyc + 1 + ADD_LAT) % NSLOT] = {2'(pa), t};
            m_busy[pa][t] = 1;
            m_add_ptr = (pa + 1) % 4;
         end
         if (ps >= 0) begin
            t = req_tag[ps*2 +: 2];
            e_si[s1] = 1; e_sc[s1] = req_cmd[ps*4 +: 4];
            e_sd1[s1] = req_data1[ps*DW +: DW]; e_sd2[s1] = req_data2[ps*DW +: DW];
            e_so[(cyc + 1 + SHIFT_LAT) % NSLOT] = 1;
            e_st[(cyc + 1 + SHIFT_LAT) % NSLOT] = {2'(ps), t};
            m_busy[ps][t] = 1;
            m_shf_ptr = (ps + 1) % 4;
         end

         e_ai[s] = 0; e_si[s] = 0; e_ao[s] = 0; e_so[s] = 0; e_inv[s] = 4'b0000;
      end
      cyc++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int p, input logic [3:0] c, input logic [1:0] t,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
      req_vld[p]           = 1'b1;
      req_cmd[p*4 +: 4]    = c;
      req_tag[p*2 +: 2]    = t;
      req_data1[p*DW +: DW] = a;
      req_data2[p*DW +: DW] = b;
   endtask

   task automatic clr_all();
      req_vld = 4'b0000;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge c_clk);
      #1;
   endtask

   task automatic do_reset();
      clr_all();
      reset = 1'b0;
      idle(2);
      reset = 1'b1;
      idle(1);
   endtask

   // Present one command and hold it until accepted; returns cycles stalled.
   task automatic send(input int p, input logic [3:0] c, input logic [1:0] t,
                       input logic [DW-1:0] a, input logic [DW-1:0] b, output int waited);
      bit got;
      got    = 0;
      waited = 0;
      set_req(p, c, t, a, b);
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge c_clk);
         if (req_rdy[p]) got = 1;
         else waited++;
      end
      @(posedge c_clk);
      #1;
      req_vld[p] = 1'b0;
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int w, seen;
      logic [3:0] g, exp_g;
      logic [1:0] rr_tag [4];
      req_vld = 0; req_cmd = 0; req_tag = 0; req_data1 = 0; req_data2 = 0;

      // Reset state.
      idle(2);
      chk("reset_adder_issue", {63'd0, prio_adder_issue}, 0);
      chk("reset_adder_cmd", {60'd0, prio_adder_cmd}, 0);
      chk("reset_adder_data1", {32'd0, prio_adder_data1}, 0);
      chk("reset_shift_cmd", {60'd0, prio_shift_cmd}, 0);
      chk("reset_shift_data2", {32'd0, prio_shift_data2}, 0);
      chk("reset_adder_tag", {60'd0, prio_adder_tag}, 0);
      chk("reset_invalid_tag", {56'd0, port_invalid_tag}, 0);
      reset = 1'b1;
      idle(1);

      // Single add on port2, tag 2, 5/7.
      set_req(1, ADD, 2'd2, 32'd5, 32'd7);
      @(negedge c_clk);
      chk("single_rdy", {60'd0, req_rdy}, 4'b0010);
      @(posedge c_clk); #1; clr_all();
      @(negedge c_clk);
      chk("single_issue", {63'd0, prio_adder_issue}, 1);
      chk("single_cmd", {60'd0, prio_adder_cmd}, 4'b0001);
      chk("single_d1", {32'd0, prio_adder_data1}, 5);
      chk("single_d2", {32'd0, prio_adder_data2}, 7);
      @(negedge c_clk);
      chk("single_not_yet", {63'd0, prio_adder_out_vld}, 0);
      @(negedge c_clk);
      chk("single_out_vld", {63'd0, prio_adder_out_vld}, 1);
      chk("single_out_tag", {60'd0, prio_adder_tag}, 4'b0110);
      @(posedge c_clk); #1;

      // Round-robin fairness: all four ports keep an add pending.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         rr_tag[p] = 2'(p);
         set_req(p, (p % 2 == 0) ? ADD : SUB, rr_tag[p], 32'(100 + p), 32'(p));
      end
      for (int k = 0; k < 8; k++) begin
         @(negedge c_clk);
         g     = req_rdy;
         exp_g = 4'b0001 << (k % 4);
         chk($sformatf("rr_grant_%0d", k), {60'd0, g}, {60'd0, exp_g});
         @(posedge c_clk); #1;
         for (int p = 0; p < 4; p++)
            if (g[p]) begin
               rr_tag[p] = rr_tag[p] + 2'd1;
               set_req(p, ADD, rr_tag[p], 32'(200 + k), 32'(k));
            end
      end
      clr_all();
      idle(6);

      // Parallel units: port1 add + port3 shl in the same cycle.
      do_reset();
      set_req(0, ADD, 2'd0, 32'd10, 32'd3);
      set_req(2, SHL, 2'd1, 32'd1, 32'd4);
      @(negedge c_clk);
      chk("par_rdy", {60'd0, req_rdy}, 4'b0101);
      @(posedge c_clk); #1; clr_all();
      @(negedge c_clk);
      chk("par_add_issue", {63'd0, prio_adder_issue}, 1);
      chk("par_shf_issue", {63'd0, prio_shift_issue}, 1);
      chk("par_shf_cmd", {60'd0, prio_shift_cmd}, 4'b0101);
      chk("par_shf_d2", {32'd0, prio_shift_data2}, 4);
      @(negedge c_clk);
      @(negedge c_clk);
      chk("par_add_done", {63'd0, prio_adder_out_vld}, 1);
      chk("par_add_tag", {60'd0, prio_adder_tag}, 4'b0000);
      chk("par_shf_not_yet", {63'd0, prio_shift_out_vld}, 0);
      @(negedge c_clk);
      chk("par_shf_done", {63'd0, prio_shift_out_vld}, 1);
      chk("par_shf_tag", {60'd0, prio_shift_tag}, 4'b1001);
      @(posedge c_clk); #1;
      send(0, ADD, 2'd0, 32'd1, 32'd2, w);
      chk("par_add_tag_free", w, 0);
      send(2, SHR, 2'd1, 32'd8, 32'd2, w);
      chk("par_shf_tag_free", w, 0);
      idle(6);

      // Busy tag blocks reissue until its result returns.
      do_reset();
      send(0, ADD, 2'd1, 32'd1, 32'd1, w);
      chk("blk_first_wait", w, 0);
      send(0, SUB, 2'd1, 32'd2, 32'd2, w);
      chk("blk_busy_tag_wait", w, 3);
      idle(6);
      // MAX_OUT=2: a third distinct tag waits for the oldest to retire.
      send(0, ADD, 2'd0, 32'd3, 32'd3, w);
      chk("lim_tag0_wait", w, 0);
      send(0, ADD, 2'd1, 32'd4, 32'd4, w);
      chk("lim_tag1_wait", w, 0);
      send(0, ADD, 2'd2, 32'd5, 32'd5, w);
      chk("lim_tag2_wait", w, 2);
      idle(6);

      // Invalid and NOP commands.
      do_reset();
      set_req(3, 4'b1111, 2'd3, 32'd0, 32'd0);
      @(negedge c_clk);
      chk("inv_rdy", {60'd0, req_rdy}, 4'b1000);
      @(posedge c_clk); #1; clr_all();
      @(negedge c_clk);
      chk("inv_pulse", {60'd0, port_invalid_op}, 4'b1000);
      chk("inv_tag", {62'd0, port_invalid_tag[7:6]}, 2'b11);
      chk("inv_no_add", {63'd0, prio_adder_issue}, 0);
      chk("inv_no_shf", {63'd0, prio_shift_issue}, 0);
      @(posedge c_clk); #1;
      set_req(1, NOP, 2'd1, 32'd9, 32'd9);
      @(negedge c_clk);
      chk("nop_rdy", {60'd0, req_rdy}, 4'b0010);
      @(posedge c_clk); #1; clr_all();
      @(negedge c_clk);
      chk("nop_no_pulse", {60'd0, port_invalid_op}, 0);
      chk("nop_no_add", {63'd0, prio_adder_issue}, 0);
      @(posedge c_clk); #1;
      set_req(0, 4'b0100, 2'd2, 32'd0, 32'd0);
      set_req(1, SUB, 2'd0, 32'd20, 32'd6);
      @(negedge c_clk);
      chk("mix_rdy", {60'd0, req_rdy}, 4'b0011);
      @(posedge c_clk); #1; clr_all();
      @(negedge c_clk);
      chk("mix_pulse", {60'd0, port_invalid_op}, 4'b0001);
      chk("mix_add_cmd", {60'd0, prio_adder_cmd}, 4'b0010);
      idle(6);

      // Reset while an add is in flight.
      do_reset();
      set_req(0, ADD, 2'd0, 32'd9, 32'd9);
      @(negedge c_clk);
      @(posedge c_clk); #1; clr_all();
      chk("mid_issue_before", {63'd0, prio_adder_issue}, 1);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_issue_cleared", {63'd0, prio_adder_issue}, 0);
      chk("mid_cmd_cleared", {60'd0, prio_adder_cmd}, 0);
      chk("mid_data_cleared", {32'd0, prio_adder_data1}, 0);
      idle(2);
      reset = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge c_clk);
         if (prio_adder_out_vld) seen++;
      end
      chk("mid_no_out_vld", seen, 0);
      @(posedge c_clk); #1;
      send(0, ADD, 2'd0, 32'd11, 32'd12, w);
      chk("mid_regrant_wait", w, 0);
      @(negedge c_clk);
      chk("mid_regrant_issue", {63'd0, prio_adder_issue}, 1);
      chk("mid_regrant_d1", {32'd0, prio_adder_data1}, 11);
      idle(6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
